fast_cmd_arbiter: RTL and testbench
===================================

FAST_CMD_ARBITER -- requirements
Module: fast_cmd_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
- ORBIT_LEN, 3564, bunch crossings (BC) per orbit.
- L1A_FIFO_DEPTH, 4, pending-L1A queue depth, power of 2.
REQ-002 Ports SHALL be, one per line:
- clk40 in 1: 40 MHz BC clock, the only clock.
- rst in 1: synchronous, active-high reset.
- bcr_en in 1: enables the periodic BCR.
- bcr_offset in 12: BC index at which BCR is issued.
- l1a_req in 1: single-cycle L1A request.
- hold_l1a in 1: discard L1A.
- l1a_min_gap in 4: minimum idle BCs between emitted L1As.
- ws_req in 1: waveform-sampler request pulse.
- ws_start in 1: polarity of ws_req; 1 = start, 0 = stop.
- seq_valid in 1: sequencer command valid.
- seq_cmd in 8: sequencer command byte.
- seq_ready out 1: sequencer command accepted this cycle.
- fc_byte out 8: fast-command byte to the serializer.
- bc_cnt out 12: current BC.
- l1a_cnt out 16: number of L1As emitted.
- l1a_drop_cnt out 16: number of L1As dropped.

Function
REQ-003 bc_cnt SHALL increment every cycle and wrap from ORBIT_LEN-1 to 0.
REQ-004 The BCR slot SHALL be active when bcr_en=1 and bc_cnt==bcr_offset; if bcr_offset>=ORBIT_LEN, no BCR SHALL ever be issued.
REQ-005 When l1a_req=1 and hold_l1a=0, the request SHALL be pushed to the L1A FIFO; when hold_l1a=1, the request SHALL be discarded and not counted.
REQ-006 A push into a full FIFO SHALL be dropped and SHALL increment l1a_drop_cnt. A push and pop in the same cycle on a full FIFO SHALL accept the push.
REQ-007 An L1A SHALL be eligible when the FIFO is non-empty and gap_cnt==0.
- gap_cnt loads l1a_min_gap when an L1A (or L1A_BCR) is emitted.
- gap_cnt otherwise decrements to 0.
- l1a_min_gap=0 allows back-to-back L1As.
REQ-008 A ws_req SHALL set a pending WS flag. A new ws_req while the flag is pending SHALL overwrite the stored polarity. The flag SHALL clear when WS is granted.
REQ-009 Selection each cycle SHALL follow this fixed priority:
- BCR slot: emits 0x99 and pops the FIFO if an L1A is eligible, else emits 0x5A.
- pending WS: emits 0xA5 if start, else 0xAA.
- eligible L1A: emits 0x96.
- seq_valid: emits seq_cmd.
- otherwise: 0xF0 (idle).
REQ-010 seq_ready SHALL be combinational: 1 iff no BCR slot, no pending WS and no eligible L1A in this cycle. It SHALL be independent of seq_valid.
REQ-011 While hold_l1a=1, sequencer bytes SHALL be filtered: 0x96 becomes 0xF0 and 0x99 becomes 0x5A.
REQ-012 fc_byte SHALL be registered, one cycle after the selection cycle.
REQ-013 l1a_cnt SHALL increment on every emitted 0x96 or 0x99 from the FIFO path, and SHALL NOT increment for sequencer bytes.
REQ-014 Both counters SHALL saturate at 0xFFFF.

Reset
REQ-015 While rst=1 the block SHALL hold these values:
- fc_byte=0xF0
- bc_cnt=0
- l1a_cnt=0
- l1a_drop_cnt=0
- gap_cnt=0
- FIFO empty
- WS pending=0
- seq_ready=0
REQ-016 Reset asserted mid-operation SHALL discard queued L1As and any pending WS without counting them as drops.
REQ-017 The first cycle after rst deasserts SHALL be BC 0.

Configuration
REQ-018 Macro FC_ARB_TRIG_RULE_EN SHALL control the minimum-gap rule.
- Defined: REQ-007 applies.
- Undefined: gap_cnt is removed, l1a_min_gap is ignored, and an L1A is eligible whenever the FIFO is non-empty.

Structure
REQ-019 Package fast_cmd_pkg SHALL hold the command byte constants:
- idle 0xF0, linkReset 0x33, BCR 0x5A, STP 0x55, L1ACR 0x66, chargeInj 0x69, L1A 0x96, L1A_BCR 0x99, WS_start 0xA5, WS_stop 0xAA.
REQ-020 The L1A queue SHALL be sub-module fc_l1a_fifo, a counter-based FIFO with full, empty, push and pop.

Verification
REQ-021 The bench SHALL cover these scenarios:
- BCR period: bcr_en=1, bcr_offset=10, ORBIT_LEN=3564 -> 0x5A at every BC 10, one cycle later, period 3564; every other cycle 0xF0.
- L1A merge: l1a_req at BC 9, l1a_min_gap=0, bcr_offset=10 -> 0x96 for BC 9. l1a_req at BC 10 -> single 0x99 for BC 10.
- Trigger rule (FC_ARB_TRIG_RULE_EN): 3 back-to-back l1a_req, l1a_min_gap=2 -> 0x96 at cycles n, n+3, n+6. l1a_cnt=3.
- FIFO overflow: 6 back-to-back l1a_req, depth 4, l1a_min_gap=15 -> l1a_drop_cnt=1 or 2 depending on pop timing per REQ-006. The bench SHALL check l1a_cnt + l1a_drop_cnt = 6.
- Sequencer/WS: seq_valid=1 with seq_cmd=0x69, ws_req with ws_start=1 in the same cycle -> 0xA5 first, seq_ready=0 that cycle; then 0x69.
- hold/reset: hold_l1a=1 with sequencer byte 0x99 -> 0x5A emitted. rst pulsed with 3 queued L1As -> no 0x96 afterwards; counters=0.

Source files
------------

// File: rtl/fast_cmd_pkg.sv
// Fast-command byte definitions and small helpers shared by the arbiter and its FIFO.
package fast_cmd_pkg;

  localparam logic [7:0] CMD_IDLE       = 8'hF0;
  localparam logic [7:0] CMD_LINK_RESET = 8'h33;
  localparam logic [7:0] CMD_BCR        = 8'h5A;
  localparam logic [7:0] CMD_STP        = 8'h55;
  localparam logic [7:0] CMD_L1ACR      = 8'h66;
  localparam logic [7:0] CMD_CHARGE_INJ = 8'h69;
  localparam logic [7:0] CMD_L1A        = 8'h96;
  localparam logic [7:0] CMD_L1A_BCR    = 8'h99;
  localparam logic [7:0] CMD_WS_START   = 8'hA5;
  localparam logic [7:0] CMD_WS_STOP    = 8'hAA;

  typedef enum logic [2:0] {
    SEL_IDLE,
    SEL_BCR,
    SEL_L1A_BCR,
    SEL_WS,
    SEL_L1A,
    SEL_SEQ
  } fcSel_t;

  // While triggers are held the sequencer must not be able to fake an L1A.
  function automatic logic [7:0] filterSeqCmd(input logic hold, input logic [7:0] cmd);
    logic [7:0] result;
    result = cmd;
    if (hold && cmd == CMD_L1A) result = CMD_IDLE;
    if (hold && cmd == CMD_L1A_BCR) result = CMD_BCR;
    return result;
  endfunction

  function automatic logic [15:0] satInc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/fc_l1a_fifo.sv
// Occupancy-counter queue of pending L1As; an L1A carries no payload, so only the count is kept.
module fc_l1a_fifo
  import fast_cmd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk40,
  input  logic rst,
  input  logic push,
  input  logic pop,
  output logic full,
  output logic empty
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0] count;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // A simultaneous push and pop leaves the level unchanged, even when full.
  always_ff @(posedge clk40) begin
    if (rst) begin
      count <= '0;
    end else if (push && pop && !empty) begin
      count <= count;
    end else if (push && !full) begin
      count <= count + CW'(1);
    end else if (pop && !empty) begin
      count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/fast_cmd_arbiter.sv
// Fast-command arbiter: merges BCR, queued L1As, waveform-sampler and sequencer bytes into one BC-rate stream.
// Define FC_ARB_TRIG_RULE_EN to enforce the minimum idle gap between emitted L1As.
module fast_cmd_arbiter
  import fast_cmd_pkg::*;
#(
  parameter int ORBIT_LEN      = 3564,
  parameter int L1A_FIFO_DEPTH = 4
) (
  input  logic        clk40,
  input  logic        rst,
  input  logic        bcr_en,
  input  logic [11:0] bcr_offset,
  input  logic        l1a_req,
  input  logic        hold_l1a,
  input  logic [3:0]  l1a_min_gap,
  input  logic        ws_req,
  input  logic        ws_start,
  input  logic        seq_valid,
  input  logic [7:0]  seq_cmd,
  output logic        seq_ready,
  output logic [7:0]  fc_byte,
  output logic [11:0] bc_cnt,
  output logic [15:0] l1a_cnt,
  output logic [15:0] l1a_drop_cnt
);

  logic   bcrSlot;
  logic   pushReq;
  logic   wsNow;
  logic   wsPolNow;
  logic   gapOpen;
  logic   l1aEligible;
  logic   l1aTaken;
  logic   fifoPush;
  logic   fifoPop;
  logic   fifoFull;
  logic   fifoEmpty;
  logic   dropEvt;
  logic   wsPending;
  logic   wsPolarity;
  fcSel_t selSrc;
  logic [7:0] nextByte;

  always_ff @(posedge clk40) begin
    if (rst) begin
      bc_cnt <= '0;
    end else if (bc_cnt == 12'(ORBIT_LEN - 1)) begin
      bc_cnt <= '0;
    end else begin
      bc_cnt <= bc_cnt + 12'd1;
    end
  end

  assign bcrSlot = !rst && bcr_en && (32'(bcr_offset) < ORBIT_LEN) && (bc_cnt == bcr_offset);

  // A request arriving this cycle is already visible to arbitration, bypassing the queue.
  assign pushReq  = !rst && l1a_req && !hold_l1a;
  assign wsNow    = !rst && (wsPending || ws_req);
  assign wsPolNow = ws_req ? ws_start : wsPolarity;

`ifdef FC_ARB_TRIG_RULE_EN
  logic [3:0] gapCnt;

  always_ff @(posedge clk40) begin
    if (rst) begin
      gapCnt <= '0;
    end else if (l1aTaken) begin
      gapCnt <= l1a_min_gap;
    end else if (gapCnt != 4'd0) begin
      gapCnt <= gapCnt - 4'd1;
    end
  end

  assign gapOpen = (gapCnt == 4'd0);
`else
  logic unusedMinGap;
  assign unusedMinGap = ^l1a_min_gap;
  assign gapOpen      = 1'b1;
`endif

  assign l1aEligible = !rst && (!fifoEmpty || pushReq) && gapOpen;
  assign seq_ready   = !rst && !bcrSlot && !wsNow && !l1aEligible;

  always_comb begin
    selSrc = SEL_IDLE;
    if (bcrSlot) begin
      selSrc = l1aEligible ? SEL_L1A_BCR : SEL_BCR;
    end else if (wsNow) begin
      selSrc = SEL_WS;
    end else if (l1aEligible) begin
      selSrc = SEL_L1A;
    end else if (seq_valid && !rst) begin
      selSrc = SEL_SEQ;
    end
  end

  always_comb begin
    nextByte = CMD_IDLE;
    case (selSrc)
      SEL_BCR:     nextByte = CMD_BCR;
      SEL_L1A_BCR: nextByte = CMD_L1A_BCR;
      SEL_WS:      nextByte = wsPolNow ? CMD_WS_START : CMD_WS_STOP;
      SEL_L1A:     nextByte = CMD_L1A;
      SEL_SEQ:     nextByte = filterSeqCmd(hold_l1a, seq_cmd);
      default:     nextByte = CMD_IDLE;
    endcase
  end

  assign l1aTaken = (selSrc == SEL_L1A_BCR) || (selSrc == SEL_L1A);
  assign fifoPop  = l1aTaken && !fifoEmpty;
  assign fifoPush = pushReq && !(l1aTaken && fifoEmpty);
  assign dropEvt  = fifoPush && fifoFull && !fifoPop;

  fc_l1a_fifo #(
    .DEPTH(L1A_FIFO_DEPTH)
  ) l1aFifo (
    .clk40(clk40),
    .rst  (rst),
    .push (fifoPush),
    .pop  (fifoPop),
    .full (fifoFull),
    .empty(fifoEmpty)
  );

  // A request granted in its own cycle never lands in the pending flag.
  always_ff @(posedge clk40) begin
    if (rst) begin
      wsPending  <= 1'b0;
      wsPolarity <= 1'b0;
    end else if (ws_req) begin
      wsPending  <= (selSrc != SEL_WS);
      wsPolarity <= ws_start;
    end else if (selSrc == SEL_WS) begin
      wsPending <= 1'b0;
    end
  end

  always_ff @(posedge clk40) begin
    if (rst) begin
      fc_byte      <= CMD_IDLE;
      l1a_cnt      <= '0;
      l1a_drop_cnt <= '0;
    end else begin
      fc_byte <= nextByte;
      if (l1aTaken) l1a_cnt <= satInc16(l1a_cnt);
      if (dropEvt) l1a_drop_cnt <= satInc16(l1a_drop_cnt);
    end
  end

endmodule

// File: tb/tb_fast_cmd_arbiter.sv
// Self-checking bench for fast_cmd_arbiter: directed scenarios plus random traffic against a queue-level model.
module tb_fast_cmd_arbiter;

  localparam int ORBIT_LEN = 3564;
  localparam int DEPTH     = 4;

  logic        clk40 = 1'b0;
  logic        rst = 1'b1;
  logic        bcr_en = 1'b0;
  logic [11:0] bcr_offset = 12'd0;
  logic        l1a_req = 1'b0;
  logic        hold_l1a = 1'b0;
  logic [3:0]  l1a_min_gap = 4'd0;
  logic        ws_req = 1'b0;
  logic        ws_start = 1'b0;
  logic        seq_valid = 1'b0;
  logic [7:0]  seq_cmd = 8'h00;
  logic        seq_ready;
  logic [7:0]  fc_byte;
  logic [11:0] bc_cnt;
  logic [15:0] l1a_cnt;
  logic [15:0] l1a_drop_cnt;

  fast_cmd_arbiter #(
    .ORBIT_LEN(ORBIT_LEN),
    .L1A_FIFO_DEPTH(DEPTH)
  ) dut (
    .clk40(clk40), .rst(rst), .bcr_en(bcr_en), .bcr_offset(bcr_offset),
    .l1a_req(l1a_req), .hold_l1a(hold_l1a), .l1a_min_gap(l1a_min_gap),
    .ws_req(ws_req), .ws_start(ws_start), .seq_valid(seq_valid), .seq_cmd(seq_cmd),
    .seq_ready(seq_ready), .fc_byte(fc_byte), .bc_cnt(bc_cnt),
    .l1a_cnt(l1a_cnt), .l1a_drop_cnt(l1a_drop_cnt)
  );

  always #5 clk40 = ~clk40;

  int testCount = 0;
  int failCount = 0;

  // Reference model state: queue occupancy as a plain integer, counters as ints.
  int   mBc = 0, mQueue = 0, mGap = 0, mL1aCnt = 0, mDropCnt = 0;
  bit   mWsPend = 0, mWsStart = 0;
  logic [7:0] mFcByte = 8'hF0;
  bit   eReady, eTaken, eArrive, eWsGrant;
  logic [7:0] eNextByte;
  logic lastReady;
  int   seen96;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    assert (observed === expected)
      else begin
        failCount++;
        $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
  endtask

  task automatic modelEvaluate();
    bit bcr, wsNow, eligible, wsPol;
    logic [7:0] s;
    eReady = 0; eTaken = 0; eArrive = 0; eWsGrant = 0; eNextByte = 8'hF0;
    if (!rst) begin
      bcr     = bcr_en && (int'(bcr_offset) < ORBIT_LEN) && (mBc == int'(bcr_offset));
      eArrive = l1a_req && !hold_l1a;
      wsNow   = mWsPend || ws_req;
      wsPol   = ws_req ? ws_start : mWsStart;
`ifdef FC_ARB_TRIG_RULE_EN
      eligible = (mQueue > 0 || eArrive) && (mGap == 0);
`else
      eligible = (mQueue > 0 || eArrive);
`endif
      eTaken   = eligible && (bcr || !wsNow);
      eWsGrant = !bcr && wsNow;
      eReady   = !bcr && !wsNow && !eligible;
      if (bcr) eNextByte = eTaken ? 8'h99 : 8'h5A;
      else if (wsNow) eNextByte = wsPol ? 8'hA5 : 8'hAA;
      else if (eligible) eNextByte = 8'h96;
      else if (seq_valid) begin
        s = seq_cmd;
        if (hold_l1a && s == 8'h96) s = 8'hF0;
        if (hold_l1a && s == 8'h99) s = 8'h5A;
        eNextByte = s;
      end
    end
  endtask

  task automatic modelAdvance();
    if (rst) begin
      mBc = 0; mQueue = 0; mGap = 0; mL1aCnt = 0; mDropCnt = 0;
      mWsPend = 0; mWsStart = 0; mFcByte = 8'hF0;
    end else begin
      mBc = (mBc + 1) % ORBIT_LEN;
      if (eArrive && !eTaken) begin
        if (mQueue == DEPTH) mDropCnt = (mDropCnt < 65535) ? mDropCnt + 1 : 65535;
        else mQueue++;
      end else if (!eArrive && eTaken) begin
        mQueue--;
      end
      if (eTaken) mL1aCnt = (mL1aCnt < 65535) ? mL1aCnt + 1 : 65535;
      if (eTaken) mGap = int'(l1a_min_gap);
      else if (mGap > 0) mGap--;
      if (eWsGrant) mWsPend = 0;
      else if (ws_req) begin
        mWsPend = 1;
        mWsStart = ws_start;
      end
      mFcByte = eNextByte;
    end
  endtask

  task automatic applyStimulus(input bit iRst, input bit iL1a, input bit iHold, input bit iWsReq,
                               input bit iWsStart, input bit iSeqValid, input logic [7:0] iSeqCmd);
    rst = iRst; l1a_req = iL1a; hold_l1a = iHold; ws_req = iWsReq;
    ws_start = iWsStart; seq_valid = iSeqValid; seq_cmd = iSeqCmd;
    #1;
    modelEvaluate();
    lastReady = seq_ready;
    checkOutput("seq_ready", {31'd0, seq_ready}, {31'd0, eReady});
    @(posedge clk40);
    modelAdvance();
    #1;
    checkOutput("fc_byte", {24'd0, fc_byte}, {24'd0, mFcByte});
    checkOutput("bc_cnt", {20'd0, bc_cnt}, mBc);
    checkOutput("l1a_cnt", {16'd0, l1a_cnt}, mL1aCnt);
    checkOutput("l1a_drop_cnt", {16'd0, l1a_drop_cnt}, mDropCnt);
    if (fc_byte == 8'h96) seen96++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 8'h00);
  endtask

  task automatic pulseReset(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0, 0, 0, 8'h00);
  endtask

  initial begin
    int bcrSeen;
    int waitCnt;
    int hits[$];

    // Reset values
    pulseReset(3);
    checkOutput("reset_fc_byte", {24'd0, fc_byte}, 32'hF0);
    checkOutput("reset_bc_cnt", {20'd0, bc_cnt}, 32'd0);
    checkOutput("reset_seq_ready", {31'd0, lastReady}, 32'd0);

    // BCR period across more than one orbit
    bcr_en = 1; bcr_offset = 12'd10;
    bcrSeen = 0;
    for (int i = 0; i < ORBIT_LEN + 15; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 8'h00);
      if (fc_byte == 8'h5A) begin
        bcrSeen++;
        checkOutput("bcr_bc_position", {20'd0, bc_cnt}, 32'd11);
      end
    end
    checkOutput("bcr_count", bcrSeen, 32'd2);

    // L1A just before and on the BCR slot
    waitCnt = 0;
    while (mBc != 9 && waitCnt < ORBIT_LEN + 5) begin
      idle(1);
      waitCnt++;
    end
    checkOutput("wait_bc9", {31'd0, mBc == 9}, 32'd1);
    l1a_min_gap = 4'd0;
    applyStimulus(0, 1, 0, 0, 0, 0, 8'h00);
    checkOutput("merge_l1a", {24'd0, fc_byte}, 32'h96);
    applyStimulus(0, 1, 0, 0, 0, 0, 8'h00);
    checkOutput("merge_l1a_bcr", {24'd0, fc_byte}, 32'h99);
    idle(2);
    checkOutput("merge_l1a_cnt", {16'd0, l1a_cnt}, 32'd2);

    // BCR offset beyond the orbit never fires
    bcr_offset = 12'd4000;
    idle(20);

    // Trigger-rule spacing of three back-to-back requests
    bcr_en = 0; l1a_min_gap = 4'd2;
    pulseReset(2);
    seen96 = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, i < 3, 0, 0, 0, 0, 8'h00);
      if (fc_byte == 8'h96) hits.push_back(i);
    end
    checkOutput("trig_hits", hits.size(), 32'd3);
`ifdef FC_ARB_TRIG_RULE_EN
    if (hits.size() == 3) begin
      checkOutput("trig_hit1", hits[1] - hits[0], 32'd3);
      checkOutput("trig_hit2", hits[2] - hits[0], 32'd6);
    end
`else
    if (hits.size() == 3) begin
      checkOutput("trig_hit1", hits[1] - hits[0], 32'd1);
      checkOutput("trig_hit2", hits[2] - hits[0], 32'd2);
    end
`endif
    checkOutput("trig_l1a_cnt", {16'd0, l1a_cnt}, 32'd3);

    // FIFO overflow with a long gap
    l1a_min_gap = 4'd15;
    pulseReset(2);
    for (int i = 0; i < 6; i++) applyStimulus(0, 1, 0, 0, 0, 0, 8'h00);
    idle(90);
    checkOutput("overflow_sum", {16'd0, l1a_cnt} + {16'd0, l1a_drop_cnt}, 32'd6);

    // WS beats the sequencer, which follows next cycle
    l1a_min_gap = 4'd0;
    applyStimulus(0, 0, 0, 1, 1, 1, 8'h69);
    checkOutput("ws_first", {24'd0, fc_byte}, 32'hA5);
    checkOutput("ws_blocks_seq", {31'd0, lastReady}, 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 1, 8'h69);
    checkOutput("seq_after_ws", {24'd0, fc_byte}, 32'h69);
    checkOutput("seq_ready_after_ws", {31'd0, lastReady}, 32'd1);

    // Hold filters trigger-looking sequencer bytes
    applyStimulus(0, 0, 1, 0, 0, 1, 8'h99);
    checkOutput("hold_99", {24'd0, fc_byte}, 32'h5A);
    applyStimulus(0, 0, 1, 0, 0, 1, 8'h96);
    checkOutput("hold_96", {24'd0, fc_byte}, 32'hF0);

    // Queue three L1As behind WS, then reset discards them
    applyStimulus(0, 1, 0, 1, 1, 0, 8'h00);
    applyStimulus(0, 1, 0, 1, 0, 0, 8'h00);
    applyStimulus(0, 1, 0, 1, 1, 0, 8'h00);
    checkOutput("queued_no_drop", {16'd0, l1a_drop_cnt}, 32'd0);
    pulseReset(2);
    seen96 = 0;
    idle(20);
    checkOutput("reset_flush_96", seen96, 32'd0);
    checkOutput("reset_flush_l1a_cnt", {16'd0, l1a_cnt}, 32'd0);
    checkOutput("reset_flush_drop", {16'd0, l1a_drop_cnt}, 32'd0);

    // Random traffic against the model
    bcr_en = 1;
    for (int i = 0; i < 3000; i++) begin
      if ((i % 200) == 0) begin
        bcr_offset  = ($urandom_range(0, 9) == 0) ? 12'd4000 : 12'(mBc + $urandom_range(1, 60));
        l1a_min_gap = 4'($urandom_range(0, 3));
      end
      applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 4, $urandom_range(0, 9) == 0,
                    $urandom_range(0, 9) == 0, 1'($urandom), $urandom_range(0, 1) == 1, 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
